// File: rtl/datapath_unit_pkg.sv
// datapath_unit_pkg: shared widths, register count and function-unit opcodes for the datapath.
package datapath_unit_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int REG_N  = 16;
    localparam int REG_AW = 4;
    typedef enum logic [3:0] {
        FS_A    = 4'h0,
        FS_INC  = 4'h1,
        FS_ADD  = 4'h2,
        FS_ADD1 = 4'h3,
        FS_ADDN = 4'h4,
        FS_SUB  = 4'h5,
        FS_DEC  = 4'h6,
        FS_A2   = 4'h7,
        FS_AND  = 4'h8,
        FS_OR   = 4'h9,
        FS_XOR  = 4'hA,
        FS_NOT  = 4'hB,
        FS_B    = 4'hC,
        FS_SHR  = 4'hD,
        FS_SHL  = 4'hE,
        FS_ZERO = 4'hF
    } fs_e;
endpackage

// File: rtl/datapath_unit_fu.sv
// function_unit: combinational ALU/shifter of the datapath; carry out is discarded.
module function_unit
    import datapath_unit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        fs,
    output logic [DATA_W-1:0] f
);
    always_comb begin
        f = '0;
        case (fs)
            FS_A, FS_A2: f = a;
            FS_INC:      f = a + DATA_W'(1);
            FS_ADD:      f = a + b;
            FS_ADD1:     f = a + b + DATA_W'(1);
            FS_ADDN:     f = a + ~b;
            FS_SUB:      f = a + ~b + DATA_W'(1);
            FS_DEC:      f = a - DATA_W'(1);
            FS_AND:      f = a & b;
            FS_OR:       f = a | b;
            FS_XOR:      f = a ^ b;
            FS_NOT:      f = ~a;
            FS_B:        f = b;
            FS_SHR:      f = b >> 1;
            FS_SHL:      f = b << 1;
            default:     f = '0;
        endcase
    end
endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: 16x16 register file, function unit and 64x16 unified memory.
// Define DATAPATH_R0_ZERO_EN to hardwire R0 to zero.
module datapath_unit
    import datapath_unit_pkg::*;
(
    input  logic              clk_main,
    input  logic              reset,
    input  logic [REG_AW-1:0] DR,
    input  logic [REG_AW-1:0] SA,
    input  logic [REG_AW-1:0] SB,
    input  logic [3:0]        FS,
    input  logic              MB,
    input  logic              MD,
    input  logic              MM,
    input  logic              MW,
    input  logic              RW,
    input  logic [ADDR_W-1:0] PC,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] mem_out,
    output logic              Z
);
`ifdef DATAPATH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] bus_b, f, d_bus;
    logic [ADDR_W-1:0] addr;
    assign bus_a   = (R0Z && SA == '0) ? '0 : regs[SA];
    assign bus_b   = MB ? {{(DATA_W-REG_AW){1'b0}}, SB} : (R0Z && SB == '0) ? '0 : regs[SB];
    function_unit u_fu (.a(bus_a), .b(bus_b), .fs(FS), .f(f));
    assign Z       = f == '0;
    assign addr    = MM ? PC : bus_a[ADDR_W-1:0];
    assign mem_out = mem[addr];
    assign d_bus   = MD ? mem_out : f;
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else if (RW && !(R0Z && DR == '0)) begin
            regs[DR] <= d_bus;
        end
    end
    // Memory is not cleared by reset, but writes are blocked while it is held low.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            if (prog_we) mem[prog_addr] <= prog_data;
            else if (MW) mem[addr] <= bus_b;
        end
    end
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: random and directed stimulus against a reference model, checked through a scoreboard queue.
module tb_datapath_unit;
`ifdef DATAPATH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif
    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] m;
        logic        mc;
        logic        z;
    } exp_t;

    logic        clk_main = 0, reset = 0;
    logic [3:0]  DR = 0, SA = 0, SB = 0, FS = 0;
    logic        MB = 0, MD = 0, MM = 0, MW = 0, RW = 0, prog_we = 0;
    logic [5:0]  PC = 0, prog_addr = 0;
    logic [15:0] prog_data = 0;
    logic [15:0] bus_a, mem_out;
    logic        Z;

    logic [15:0] mregs [16];
    logic [15:0] mmem [64];
    bit          mok [64];
    exp_t        q[$];
    int          n_chk = 0, n_fail = 0;
    bit          ka_en = 0, km_en = 0, kz_en = 0;
    logic [15:0] ka, km;
    logic        kz;

    datapath_unit dut (
        .clk_main(clk_main), .reset(reset), .DR(DR), .SA(SA), .SB(SB), .FS(FS),
        .MB(MB), .MD(MD), .MM(MM), .MW(MW), .RW(RW), .PC(PC),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .bus_a(bus_a), .mem_out(mem_out), .Z(Z)
    );

    always #5 clk_main = ~clk_main;

    function automatic logic [15:0] fu(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
        case (fs)
            4'h1: return a + 1;
            4'h2: return a + b;
            4'h3: return a + b + 1;
            4'h4: return a + ~b;
            4'h5: return a - b;
            4'h6: return a - 1;
            4'h8: return a & b;
            4'h9: return a | b;
            4'hA: return a ^ b;
            4'hB: return ~a;
            4'hC: return b;
            4'hD: return b / 2;
            4'hE: return b * 2;
            4'hF: return 16'h0000;
            default: return a;
        endcase
    endfunction

    function automatic logic [15:0] rd(input logic [3:0] i);
        return (R0Z && i == 0) ? 16'h0 : mregs[i];
    endfunction

    // One clock of stimulus: predict, queue the prediction, then commit the model at the edge.
    task automatic cyc(input string tag);
        exp_t e;
        logic [15:0] ra, b, f, mo;
        logic [5:0]  ad;
        if (!reset) for (int i = 0; i < 16; i++) mregs[i] = 0;
        ra = rd(SA);
        b  = MB ? {12'h0, SB} : rd(SB);
        f  = fu(FS, ra, b);
        ad = MM ? PC : ra[5:0];
        mo = mmem[ad];
        e.tag = tag;
        e.a   = ka_en ? ka : ra;
        e.m   = km_en ? km : mo;
        e.mc  = km_en || mok[ad];
        e.z   = kz_en ? kz : (f == 0);
        ka_en = 0; km_en = 0; kz_en = 0;
        q.push_back(e);
        @(posedge clk_main);
        if (reset) begin
            if (prog_we) begin mmem[prog_addr] = prog_data; mok[prog_addr] = 1; end
            else if (MW) begin mmem[ad] = b; mok[ad] = 1; end
            if (RW && !(R0Z && DR == 0)) mregs[DR] = MD ? mo : f;
        end
        #1;
    endtask

    task automatic idle();
        MB = 0; MD = 0; MM = 0; MW = 0; RW = 0; prog_we = 0; FS = 0;
    endtask

    always @(negedge clk_main) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (bus_a !== e.a) begin n_fail++; $display("FAIL %s bus_a got %h want %h", e.tag, bus_a, e.a); end
            n_chk++;
            if (Z !== e.z) begin n_fail++; $display("FAIL %s Z got %b want %b", e.tag, Z, e.z); end
            if (e.mc) begin
                n_chk++;
                if (mem_out !== e.m) begin n_fail++; $display("FAIL %s mem_out got %h want %h", e.tag, mem_out, e.m); end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = 0;
        for (int i = 0; i < 64; i++) begin mmem[i] = 0; mok[i] = 0; end
        @(posedge clk_main); #1;
        for (int i = 0; i < 16; i++) begin SA = 4'(i); ka_en = 1; ka = 0; cyc("rst_regs"); end
        reset = 1;
        for (int i = 0; i < 64; i++) begin
            prog_we = 1; prog_addr = 6'(i); prog_data = 16'($urandom); cyc("preload");
        end
        idle(); MM = 1; PC = 10; MD = 1; RW = 1; DR = 1; cyc("load_r1");
        idle(); SA = 1; cyc("r1_loaded");
        // reset pulse mid-run: registers clear at once, writes are blocked, memory survives
        reset = 0; SA = 1; RW = 1; DR = 1; MW = 1; prog_we = 1; prog_addr = 10; prog_data = 16'hDEAD;
        ka_en = 1; ka = 0; cyc("rst_async");
        SA = 2; ka_en = 1; ka = 0; cyc("rst_hold");
        reset = 1; idle();
        for (int i = 0; i < 16; i++) begin SA = 4'(i); ka_en = 1; ka = 0; cyc("post_rst_reg"); end
        MM = 1;
        for (int i = 0; i < 64; i++) begin PC = 6'(i); cyc("post_rst_mem"); end
        idle(); MB = 1; FS = 4'hC; SB = 5; DR = 1; RW = 1; cyc("set_r1");
        SB = 3; DR = 2; cyc("set_r2");
        idle(); FS = 4'h5; SA = 1; SB = 2; DR = 3; RW = 1; ka_en = 1; ka = 5; kz_en = 1; kz = 0; cyc("sub_r3");
        idle(); SA = 3; ka_en = 1; ka = 16'h0002; cyc("r3_eq_2");
        FS = 4'h5; SA = 1; SB = 1; kz_en = 1; kz = 1; cyc("sub_zero");
        idle(); MB = 1; SB = 4'hA; FS = 4'h2; SA = 1; DR = 4; RW = 1; kz_en = 1; kz = 0; cyc("add_const");
        idle(); SA = 4; ka_en = 1; ka = 16'h000F; cyc("r4_eq_f");
        MB = 1; SB = 7; FS = 4'hC; DR = 5; RW = 1; cyc("set_r5_7");
        idle(); SA = 0; FS = 4'hB; DR = 8; RW = 1; cyc("set_r8_ffff");
        idle(); prog_we = 1; prog_addr = 7; prog_data = 16'h1234; MW = 1; SA = 5; SB = 8;
        ka_en = 1; ka = 16'h0007; cyc("prog_vs_mw");
        idle(); MM = 1; PC = 7; km_en = 1; km = 16'h1234; cyc("prog_wins");
        idle(); prog_we = 1; prog_addr = 20; prog_data = 16'h0045; cyc("prog20");
        prog_addr = 21; prog_data = 16'hBEEF; cyc("prog21");
        prog_addr = 22; prog_data = 16'h0055; cyc("prog22");
        idle(); MM = 1; MD = 1; RW = 1; PC = 20; DR = 9; cyc("ld_r9");
        PC = 21; DR = 10; cyc("ld_r10");
        idle(); MW = 1; SA = 9; SB = 10; ka_en = 1; ka = 16'h0045; cyc("mw_store");
        idle(); MD = 1; RW = 1; DR = 6; SA = 9; km_en = 1; km = 16'hBEEF; cyc("md_load");
        idle(); SA = 6; ka_en = 1; ka = 16'hBEEF; cyc("r6_beef");
        MM = 1; MD = 1; RW = 1; PC = 22; DR = 0; cyc("r0_write");
        idle(); SA = 0; ka_en = 1; ka = R0Z ? 16'h0000 : 16'h0055; cyc("r0_read");
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) != 0);
            DR = 4'($urandom); SA = 4'($urandom); SB = 4'($urandom); FS = 4'($urandom);
            MB = 1'($urandom); MD = 1'($urandom); MM = 1'($urandom); MW = 1'($urandom);
            RW = 1'($urandom); PC = 6'($urandom);
            prog_we = ($urandom_range(0, 7) == 0); prog_addr = 6'($urandom); prog_data = 16'($urandom);
            cyc("random");
        end
        reset = 1; idle();
        repeat (2) @(negedge clk_main);
        n_chk++;
        if (q.size() != 0) begin n_fail++; $display("FAIL drain pending got %0d want 0", q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 clk_main  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 DR, SA, SB  input  4 each  destination, source-A and source-B register indices; SB also serves as the 4-bit constant.
REQ-004 FS  input  4  function-unit select.
REQ-005 MB, MD, MM, MW, RW  input  1 each  const select, D-bus source, memory address source, memory write, register write.
REQ-006 PC  input  6  program counter, used as memory address when MM=1.
REQ-007 prog_we, prog_addr[5:0], prog_data[15:0]  input  bench/loader memory write port.
REQ-008 bus_a  output  16  register-file port A value.
REQ-009 mem_out  output  16  memory read data; feeds the control path's instruction input.
REQ-010 Z  output  1  high when the function-unit result is 16'h0000.

Function
REQ-011 Register file SHALL be 16 x 16-bit, with two asynchronous read ports (SA->bus_a, SB->B) and one synchronous write port.
REQ-012 Bus B SHALL equal {12'b0,SB} when MB=1, else register[SB].
REQ-013 The function unit SHALL be combinational and operate on A=bus_a, B=bus B, result 16-bit, carry discarded.
REQ-014 FS codes: 0 A; 1 A+1; 2 A+B; 3 A+B+1; 4 A+~B; 5 A-B; 6 A-1; 7 A; 8 A&B; 9 A|B; A A^B; B ~A; C B; D B>>1 (logical); E B<<1; F 16'h0000.
REQ-015 Z SHALL be combinational from the function-unit result, with zero added latency.
REQ-016 Unified memory SHALL be 64 x 16-bit, asynchronous read, synchronous write.
REQ-017 Memory address SHALL be PC when MM=1, else bus_a[5:0]; upper address bits are ignored.
REQ-018 mem_out SHALL equal memory[address] combinationally.
REQ-019 When MW=1 at a clock edge, memory[address] SHALL be loaded with bus B.
REQ-020 When prog_we=1 at a clock edge, memory[prog_addr] SHALL be loaded with prog_data, and MW SHALL be ignored that cycle (prog_we has priority).
REQ-021 D bus SHALL be mem_out when MD=1, else the function-unit result; when RW=1, register[DR] SHALL be loaded with the D bus at the clock edge.
REQ-022 Read-during-write to the same register SHALL return the old value until the edge (no bypass).
REQ-023 When DR=SA and RW=1, the updated value SHALL appear on bus_a in the cycle after the edge.

Reset
REQ-024 Reset assertion SHALL clear all 16 registers to 16'h0000 immediately, independent of clk_main.
REQ-025 Memory contents SHALL NOT be affected by reset.
REQ-026 While reset is low, RW, MW and prog_we SHALL have no effect.
REQ-027 On reset deassertion, writes SHALL resume at the first rising edge.

Configuration
REQ-028 Macro DATAPATH_R0_ZERO_EN, when defined: register 0 SHALL always read 16'h0000, and writes to DR=0 SHALL be discarded.
REQ-029 When DATAPATH_R0_ZERO_EN is undefined: R0 SHALL be a normal writable register.

Structure
REQ-030 A shared package SHALL hold the FS opcode constants, the data width (16), the address width (6) and the register count (16).
REQ-031 The function unit SHALL be a separate combinational sub-module named function_unit.
REQ-032 The register file and memory SHALL be inline in datapath_unit.

Verification
REQ-033 Reset low, then preload R1 via prog/MD path; release reset: all registers read 0, and memory contents are unchanged.
REQ-034 R1=5, R2=3; FS=5, SA=1, SB=2, DR=3, RW=1: R3=2 and Z=0; then FS=5, SA=1, SB=1: Z=1.
REQ-035 MB=1, SB=4'hA, FS=2, SA=1 (R1=5), DR=4: R4=16'h000F.
REQ-036 prog_we writes 16'h1234 at address 7; MM=1, PC=7: mem_out=16'h1234; same-cycle MW=1 with bus_a=7 and B=16'hFFFF: memory[7] remains 16'h1234.
REQ-037 MW=1, MM=0, bus_a=16'h0045 (address 5), B=16'hBEEF; next cycle MD=1, DR=6, RW=1: R6=16'hBEEF.
REQ-038 RW=1, DR=0, D bus=16'h0055: R0 reads 0 with DATAPATH_R0_ZERO_EN defined, and 16'h0055 without it.
